// File: rtl/mc_proc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_proc_sequencer_if
// Bundle between the multi-cycle processor sequencer and its datapath.
//
// Datapath -> sequencer : opcode, imem_rdy, br_taken, mem_ack
// Sequencer -> datapath : ir_wr, pc_wr, pc_sel, reg_wr, wb_sel, alu_src,
//                         alu_ctrl, mem_req, mem_we, mdr_wr
// Sequencer status      : state, illegal, bus_err, cyc_cnt, ret_cnt
//
// Modports:
//   master - the sequencer (drives the control strobes and status)
//   slave  - the datapath / environment (drives opcode and handshakes)
// ---------------------------------------------------------------------------
interface mc_proc_sequencer_if;
    logic [7:0]  opcode;
    logic        imem_rdy;
    logic        br_taken;
    logic        mem_ack;

    logic        ir_wr;
    logic        pc_wr;
    logic [1:0]  pc_sel;
    logic        reg_wr;
    logic [1:0]  wb_sel;
    logic        alu_src;
    logic [7:0]  alu_ctrl;
    logic        mem_req;
    logic        mem_we;
    logic        mdr_wr;

    logic [2:0]  state;
    logic        illegal;
    logic        bus_err;
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;

    modport master (
        input  opcode, imem_rdy, br_taken, mem_ack,
        output ir_wr, pc_wr, pc_sel, reg_wr, wb_sel, alu_src, alu_ctrl,
               mem_req, mem_we, mdr_wr,
               state, illegal, bus_err, cyc_cnt, ret_cnt
    );

    modport slave (
        output opcode, imem_rdy, br_taken, mem_ack,
        input  ir_wr, pc_wr, pc_sel, reg_wr, wb_sel, alu_src, alu_ctrl,
               mem_req, mem_we, mdr_wr,
               state, illegal, bus_err, cyc_cnt, ret_cnt
    );
endinterface

// File: rtl/mc_proc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_proc_sequencer
// Control FSM of a multi-cycle processor: fetch, decode, execute, data
// memory access and write-back, with sticky illegal-opcode and memory
// timeout flags.
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous, active-high; forces FETCH and clears all flags
//   bus   - mc_proc_sequencer_if.master (opcode/handshakes in, control
//           strobes and status out)
//
// Parameters:
//   MEM_TIMEOUT - data-memory ack wait limit in cycles (1..255)
//   ALU_ADD     - alu_ctrl code used for address computation
//
// Optional feature macro: MC_SEQ_PERF_CNT_EN
//   defined   - cyc_cnt / ret_cnt performance counters are built
//   undefined - both counter outputs are tied to zero
//
// State | meaning
// ------+--------------------------------------------------------------
// FETCH | wait for imem_rdy, latch IR and advance PC to PC+4
// DECODE| classify op1; illegal class goes to HALT
// EXEC  | drive ALU; branches and JAL complete here
// MEM   | data-memory request until ack or timeout
// WB    | register-file write from ALU or MDR
// HALT  | all strobes low; left only through reset
// ---------------------------------------------------------------------------
module mc_proc_sequencer #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [7:0] ALU_ADD     = 8'h07
) (
    input  logic                   clk,
    input  logic                   reset,
    mc_proc_sequencer_if.master    bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALUR,
        C_ALUI,
        C_LW,
        C_SW,
        C_BR,
        C_JAL,
        C_ILL
    } cls_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    // Last wait-counter value before the timeout fires: the counter reads
    // 0 in the first MEM cycle, so MEM_TIMEOUT-1 marks the final cycle.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    cls_t        w_cls;
    logic        r_illegal;
    logic        r_bus_err;
    logic [7:0]  r_wait_cnt;

    logic        w_set_illegal;
    logic        w_set_bus_err;
    logic        w_ir_wr;
    logic        w_pc_wr;
    logic [1:0]  w_pc_sel;
    logic        w_reg_wr;
    logic [1:0]  w_wb_sel;
    logic        w_alu_src;
    logic [7:0]  w_alu_ctrl;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_mdr_wr;

    always_comb begin
        case (bus.opcode[7:4])
            4'h0:    w_cls = C_ALUR;
            4'h8:    w_cls = C_ALUI;
            4'h9:    w_cls = C_LW;
            4'h5:    w_cls = C_SW;
            4'h2:    w_cls = C_BR;
            4'hB:    w_cls = C_JAL;
            default: w_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
            // Held at zero outside MEM, so every MEM entry starts from 0.
            if (r_state == S_MEM) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        w_ir_wr       = 1'b0;
        w_pc_wr       = 1'b0;
        w_pc_sel      = PC_PLUS4;
        w_reg_wr      = 1'b0;
        w_wb_sel      = WB_ALU;
        w_alu_src     = 1'b0;
        w_alu_ctrl    = 8'h00;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_mdr_wr      = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (bus.imem_rdy) begin
                    w_ir_wr  = 1'b1;
                    w_pc_wr  = 1'b1;
                    w_pc_sel = PC_PLUS4;
                    w_next   = S_DECODE;
                end
            end

            S_DECODE: begin
                if (w_cls == C_ILL) begin
                    w_set_illegal = 1'b1;
                    w_next        = S_HALT;
                end else begin
                    w_next = S_EXEC;
                end
            end

            S_EXEC: begin
                case (w_cls)
                    C_ALUR: begin
                        w_alu_ctrl = bus.opcode;
                        w_next     = S_WB;
                    end
                    C_ALUI: begin
                        w_alu_ctrl = bus.opcode;
                        w_alu_src  = 1'b1;
                        w_next     = S_WB;
                    end
                    C_LW, C_SW: begin
                        w_alu_ctrl = ALU_ADD;
                        w_alu_src  = 1'b1;
                        w_next     = S_MEM;
                    end
                    C_BR: begin
                        w_alu_ctrl = bus.opcode;
                        w_pc_wr    = bus.br_taken;
                        w_pc_sel   = PC_BRANCH;
                        w_next     = S_FETCH;
                    end
                    C_JAL: begin
                        w_alu_ctrl = ALU_ADD;
                        w_alu_src  = 1'b1;
                        w_pc_wr    = 1'b1;
                        w_pc_sel   = PC_ALU;
                        w_reg_wr   = 1'b1;
                        w_wb_sel   = WB_PC;
                        w_next     = S_FETCH;
                    end
                    default: begin
                        // Opcode changed to an illegal class after decode.
                        w_set_illegal = 1'b1;
                        w_next        = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                w_mem_req  = 1'b1;
                w_mem_we   = (w_cls == C_SW);
                w_alu_ctrl = ALU_ADD;
                w_alu_src  = 1'b1;
                // An ack in the final wait cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    if (w_cls == C_SW) begin
                        w_next = S_FETCH;
                    end else begin
                        w_mdr_wr = 1'b1;
                        w_next   = S_WB;
                    end
                end else if (r_wait_cnt == TO_LAST) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_HALT;
                end
            end

            S_WB: begin
                w_reg_wr = 1'b1;
                w_wb_sel = (w_cls == C_LW) ? WB_MDR : WB_ALU;
                w_next   = S_FETCH;
            end

            S_HALT: begin
                w_next = S_HALT;
            end

            default: begin
                w_next = S_HALT;
            end
        endcase

        // Strobes are silenced in the cycle reset is sampled, even mid-MEM.
        if (reset) begin
            w_ir_wr    = 1'b0;
            w_pc_wr    = 1'b0;
            w_pc_sel   = PC_PLUS4;
            w_reg_wr   = 1'b0;
            w_wb_sel   = WB_ALU;
            w_alu_src  = 1'b0;
            w_alu_ctrl = 8'h00;
            w_mem_req  = 1'b0;
            w_mem_we   = 1'b0;
            w_mdr_wr   = 1'b0;
        end
    end

    assign bus.ir_wr    = w_ir_wr;
    assign bus.pc_wr    = w_pc_wr;
    assign bus.pc_sel   = w_pc_sel;
    assign bus.reg_wr   = w_reg_wr;
    assign bus.wb_sel   = w_wb_sel;
    assign bus.alu_src  = w_alu_src;
    assign bus.alu_ctrl = w_alu_ctrl;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_we   = w_mem_we;
    assign bus.mdr_wr   = w_mdr_wr;
    assign bus.state    = r_state;
    assign bus.illegal  = r_illegal;
    assign bus.bus_err  = r_bus_err;

`ifdef MC_SEQ_PERF_CNT_EN
    logic        w_retire;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ret_cnt;

    // Retire points: branch/JAL leaving EXEC, store ack, any WB exit.
    assign w_retire = ((r_state == S_EXEC) && ((w_cls == C_BR) || (w_cls == C_JAL)))
                   || ((r_state == S_MEM) && bus.mem_ack && (w_cls == C_SW))
                   ||  (r_state == S_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc_cnt <= 32'd0;
            r_ret_cnt <= 32'd0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_retire) begin
                r_ret_cnt <= r_ret_cnt + 32'd1;
            end
        end
    end

    assign bus.cyc_cnt = r_cyc_cnt;
    assign bus.ret_cnt = r_ret_cnt;
`else
    assign bus.cyc_cnt = 32'd0;
    assign bus.ret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_proc_sequencer.sv
module tb_mc_proc_sequencer;

    typedef struct packed {
        logic        ir_wr;
        logic        pc_wr;
        logic [1:0]  pc_sel;
        logic        reg_wr;
        logic [1:0]  wb_sel;
        logic        alu_src;
        logic [7:0]  alu_ctrl;
        logic        mem_req;
        logic        mem_we;
        logic        mdr_wr;
        logic [2:0]  state;
        logic        illegal;
        logic        bus_err;
        logic [31:0] cyc_cnt;
        logic [31:0] ret_cnt;
    } obs_t;

    logic clk;
    logic reset;

    mc_proc_sequencer_if sif();

    mc_proc_sequencer #(
        .MEM_TIMEOUT (16),
        .ALU_ADD     (8'h07)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t  q_exp[$];
    string q_name[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Model of the visible counter and flag values in the current cycle.
    logic [31:0] m_cyc;
    logic [31:0] m_ret;
    logic        m_ill;
    logic        m_berr;

    // Monitor: every expectation queued for this cycle is checked here.
    obs_t  mon_exp;
    obs_t  mon_got;
    string mon_name;
    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            mon_exp  = q_exp.pop_front();
            mon_name = q_name.pop_front();
            mon_got.ir_wr    = sif.ir_wr;
            mon_got.pc_wr    = sif.pc_wr;
            mon_got.pc_sel   = sif.pc_sel;
            mon_got.reg_wr   = sif.reg_wr;
            mon_got.wb_sel   = sif.wb_sel;
            mon_got.alu_src  = sif.alu_src;
            mon_got.alu_ctrl = sif.alu_ctrl;
            mon_got.mem_req  = sif.mem_req;
            mon_got.mem_we   = sif.mem_we;
            mon_got.mdr_wr   = sif.mdr_wr;
            mon_got.state    = sif.state;
            mon_got.illegal  = sif.illegal;
            mon_got.bus_err  = sif.bus_err;
            mon_got.cyc_cnt  = sif.cyc_cnt;
            mon_got.ret_cnt  = sif.ret_cnt;
            n_tests++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                         mon_name, mon_got.state, mon_got, mon_exp.state, mon_exp);
            end
        end
    end

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic obs_t mem_obs(input logic we, input logic mdr);
        obs_t o;
        o = base(3'd3);
        o.mem_req  = 1'b1;
        o.mem_we   = we;
        o.mdr_wr   = mdr;
        o.alu_ctrl = 8'h07;
        o.alu_src  = 1'b1;
        return o;
    endfunction

    task automatic step(input logic rst, input logic [7:0] op, input logic irdy,
                        input logic brt, input logic ack, input obs_t e,
                        input bit retire, input string name);
        reset        = rst;
        sif.opcode   = op;
        sif.imem_rdy = irdy;
        sif.br_taken = brt;
        sif.mem_ack  = ack;
        e.illegal = m_ill;
        e.bus_err = m_berr;
`ifdef MC_SEQ_PERF_CNT_EN
        e.cyc_cnt = m_cyc;
        e.ret_cnt = m_ret;
`else
        e.cyc_cnt = 32'd0;
        e.ret_cnt = 32'd0;
`endif
        q_exp.push_back(e);
        q_name.push_back(name);
        @(posedge clk);
        #1;
        if (rst) begin
            m_cyc  = 32'd0;
            m_ret  = 32'd0;
            m_ill  = 1'b0;
            m_berr = 1'b0;
        end else begin
            m_cyc = m_cyc + 32'd1;
            if (retire) m_ret = m_ret + 32'd1;
        end
    endtask

    task automatic fetch_decode(input logic [7:0] op, input string pfx);
        obs_t e;
        e = base(3'd0);
        e.ir_wr = 1'b1;
        e.pc_wr = 1'b1;
        step(1'b0, op, 1'b1, 1'b0, 1'b0, e, 1'b0, {pfx, "_fetch"});
        e = base(3'd1);
        step(1'b0, op, 1'b0, 1'b0, 1'b0, e, 1'b0, {pfx, "_decode"});
    endtask

    task automatic exec_addr(input logic [7:0] op, input string pfx);
        obs_t e;
        e = base(3'd2);
        e.alu_ctrl = 8'h07;
        e.alu_src  = 1'b1;
        step(1'b0, op, 1'b0, 1'b0, 1'b0, e, 1'b0, {pfx, "_exec"});
    endtask

    initial begin
        obs_t e;
        reset        = 1'b1;
        sif.opcode   = 8'h00;
        sif.imem_rdy = 1'b0;
        sif.br_taken = 1'b0;
        sif.mem_ack  = 1'b0;
        m_cyc  = 32'd0;
        m_ret  = 32'd0;
        m_ill  = 1'b0;
        m_berr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with imem_rdy high: FETCH, no strobes.
        e = base(3'd0);
        step(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, e, 1'b0, "reset_fetch");

        // ALUR 8'h07: FETCH, DECODE, EXEC, WB, FETCH.
        fetch_decode(8'h07, "alur");
        e = base(3'd2); e.alu_ctrl = 8'h07;
        step(1'b0, 8'h07, 1'b0, 1'b0, 1'b0, e, 1'b0, "alur_exec");
        e = base(3'd4); e.reg_wr = 1'b1;
        step(1'b0, 8'h07, 1'b0, 1'b0, 1'b0, e, 1'b1, "alur_wb");
        e = base(3'd0);
        step(1'b0, 8'h07, 1'b0, 1'b0, 1'b1, e, 1'b0, "fetch_hold_ack_ignored");

        // LW 8'h90, ack on the third MEM cycle; ack during EXEC ignored.
        fetch_decode(8'h90, "lw");
        e = base(3'd2); e.alu_ctrl = 8'h07; e.alu_src = 1'b1;
        step(1'b0, 8'h90, 1'b0, 1'b0, 1'b1, e, 1'b0, "lw_exec_ack_ignored");
        for (int i = 0; i < 3; i++) begin
            e = mem_obs(1'b0, (i == 2));
            step(1'b0, 8'h90, 1'b0, 1'b0, (i == 2), e, 1'b0, "lw_mem");
        end
        e = base(3'd4); e.reg_wr = 1'b1; e.wb_sel = 2'd1;
        step(1'b0, 8'h90, 1'b0, 1'b0, 1'b0, e, 1'b1, "lw_wb");

        // ALUI 8'h8C: immediate source, opcode as ALU control.
        fetch_decode(8'h8C, "alui");
        e = base(3'd2); e.alu_ctrl = 8'h8C; e.alu_src = 1'b1;
        step(1'b0, 8'h8C, 1'b0, 1'b0, 1'b0, e, 1'b0, "alui_exec");
        e = base(3'd4); e.reg_wr = 1'b1;
        step(1'b0, 8'h8C, 1'b0, 1'b0, 1'b0, e, 1'b1, "alui_wb");

        // SW 8'h5A, ack in the first MEM cycle.
        fetch_decode(8'h5A, "sw");
        exec_addr(8'h5A, "sw");
        e = mem_obs(1'b1, 1'b0);
        step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, e, 1'b1, "sw_mem_ack_first");
        e = base(3'd0);
        step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, e, 1'b0, "sw_back_to_fetch");

        // BR taken, then BR not taken.
        fetch_decode(8'h23, "br_t");
        e = base(3'd2); e.alu_ctrl = 8'h23; e.pc_wr = 1'b1; e.pc_sel = 2'd1;
        step(1'b0, 8'h23, 1'b0, 1'b1, 1'b0, e, 1'b1, "br_taken_exec");
        fetch_decode(8'h2F, "br_nt");
        e = base(3'd2); e.alu_ctrl = 8'h2F; e.pc_sel = 2'd1;
        step(1'b0, 8'h2F, 1'b0, 1'b0, 1'b0, e, 1'b1, "br_not_taken_exec");

        // JAL 8'hB4: PC from ALU and link write in the same cycle.
        fetch_decode(8'hB4, "jal");
        e = base(3'd2); e.alu_ctrl = 8'h07; e.alu_src = 1'b1;
        e.pc_wr = 1'b1; e.pc_sel = 2'd2; e.reg_wr = 1'b1; e.wb_sel = 2'd2;
        step(1'b0, 8'hB4, 1'b0, 1'b0, 1'b0, e, 1'b1, "jal_exec");
        e = base(3'd0);
        step(1'b0, 8'hB4, 1'b0, 1'b0, 1'b0, e, 1'b0, "jal_back_to_fetch");

        // LW with ack in the 16th (last allowed) MEM cycle: no timeout.
        fetch_decode(8'h9F, "lw16");
        exec_addr(8'h9F, "lw16");
        for (int i = 0; i < 16; i++) begin
            e = mem_obs(1'b0, (i == 15));
            step(1'b0, 8'h9F, 1'b0, 1'b0, (i == 15), e, 1'b0, "lw16_mem");
        end
        e = base(3'd4); e.reg_wr = 1'b1; e.wb_sel = 2'd1;
        step(1'b0, 8'h9F, 1'b0, 1'b0, 1'b0, e, 1'b1, "lw16_wb");

        // Reset asserted mid-MEM: strobes drop that cycle, FETCH next.
        fetch_decode(8'h91, "lw_rst");
        exec_addr(8'h91, "lw_rst");
        e = mem_obs(1'b0, 1'b0);
        step(1'b0, 8'h91, 1'b0, 1'b0, 1'b0, e, 1'b0, "lw_rst_mem");
        e = base(3'd3);
        step(1'b1, 8'h91, 1'b0, 1'b0, 1'b1, e, 1'b0, "reset_mid_mem");
        e = base(3'd0);
        step(1'b0, 8'h91, 1'b0, 1'b0, 1'b0, e, 1'b0, "after_reset_mid_mem");

        // SW with no ack: 16 MEM cycles, then HALT with bus_err.
        fetch_decode(8'h50, "sw_to");
        exec_addr(8'h50, "sw_to");
        for (int i = 0; i < 16; i++) begin
            e = mem_obs(1'b1, 1'b0);
            step(1'b0, 8'h50, 1'b0, 1'b0, 1'b0, e, 1'b0, "sw_to_mem");
        end
        m_berr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = base(3'd5);
            step(1'b0, 8'h50, 1'b1, 1'b1, 1'b1, e, 1'b0, "timeout_halt");
        end
        e = base(3'd5);
        step(1'b1, 8'h50, 1'b0, 1'b0, 1'b0, e, 1'b0, "reset_in_halt_berr");
        e = base(3'd0);
        step(1'b0, 8'h50, 1'b0, 1'b0, 1'b0, e, 1'b0, "after_reset_berr");

        // Illegal opcode 8'hF0: DECODE sets illegal, HALT until reset.
        e = base(3'd0); e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        step(1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, e, 1'b0, "ill_fetch");
        e = base(3'd1);
        step(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, e, 1'b0, "ill_decode");
        m_ill = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = base(3'd5);
            step(1'b0, 8'hF0, 1'b1, 1'b0, 1'b1, e, 1'b0, "ill_halt");
        end
        e = base(3'd5);
        step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, e, 1'b0, "reset_in_halt_ill");
        e = base(3'd0); e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        step(1'b0, 8'h07, 1'b1, 1'b0, 1'b0, e, 1'b0, "after_reset_ill_fetch");

        @(negedge clk);
        #1;
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
